// File: rtl/fib_pkg.sv
// Shared types for the Fibonacci term buffer.
// Optional index tracking is enabled in the top with FIB_BUF_INDEX_EN.
package fib_pkg;

    localparam int FIB_IDX_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVF  = 2'd2
    } fib_buf_state_t;

endpackage

// File: rtl/fib_sync_fifo.sv
// Plain synchronous FIFO with a registered head; the caller owns all push/pop policy.
// Pointers carry one extra bit so full and empty differ only by the MSB.
module fib_sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]           r_wptr;
    logic [AW:0]           r_rptr;
    logic [DATA_WIDTH-1:0] r_head;
    logic [AW:0]           w_wptr_next;
    logic [AW:0]           w_rptr_next;

    assign empty       = (r_wptr == r_rptr);
    assign full        = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_wptr_next = r_wptr + {{AW{1'b0}}, push};
    assign w_rptr_next = r_rptr + {{AW{1'b0}}, pop};
    assign head        = r_head;

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wptr[AW-1:0]] <= din;
        end
    end

    // The head register is preloaded with whatever entry will sit at the read
    // pointer next cycle; when that entry is the one being written now, take din.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_head <= '0;
        end else begin
            r_wptr <= w_wptr_next;
            r_rptr <= w_rptr_next;
            if (w_wptr_next != w_rptr_next) begin
                r_head <= (w_rptr_next == r_wptr) ? din : r_mem[w_rptr_next[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/fib_term_buffer.sv
// Buffers a free-running Fibonacci term stream, flags sequence wrap and counts dropped terms.
// Define FIB_BUF_INDEX_EN to add out_index, the sequence index stored with each entry.
module fib_term_buffer
    import fib_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int DROP_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_term,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_term,
    output logic                  overflow,
    output logic [DROP_WIDTH-1:0] dropped,
`ifdef FIB_BUF_INDEX_EN
    output logic [FIB_IDX_W-1:0]  out_index,
`endif
    output fib_buf_state_t        dbg_state
);

    // Handshake: a head transfer happens on every rising edge where
    // out_valid & out_ready; out_valid depends on registered state only.

`ifdef FIB_BUF_INDEX_EN
    localparam int FW = DATA_WIDTH + FIB_IDX_W;
`else
    localparam int FW = DATA_WIDTH;
`endif

    fib_buf_state_t        r_state;
    logic                  r_overflow;
    logic [DATA_WIDTH-1:0] r_last;
    logic [DROP_WIDTH-1:0] r_dropped;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_wrap;
    logic                  w_take;
    logic                  w_push;
    logic                  w_drop;
    logic [FW-1:0]         w_din;
    logic [FW-1:0]         w_head;

    assign w_pop  = out_valid & out_ready;
    assign w_wrap = in_valid && (r_state == RUN) && (in_term < r_last);
    assign w_take = in_valid && (r_state != OVF) && !w_wrap;
    assign w_push = w_take && (!w_full || w_pop);
    assign w_drop = w_take && w_full && !w_pop;

    assign out_valid = !w_empty;
    assign overflow  = r_overflow;
    assign dropped   = r_dropped;
    assign dbg_state = r_state;

`ifdef FIB_BUF_INDEX_EN
    logic [FIB_IDX_W-1:0] r_index;

    assign w_din     = {r_index, in_term};
    assign out_term  = w_head[DATA_WIDTH-1:0];
    assign out_index = w_head[FW-1:DATA_WIDTH];

    // Dropped terms still consume an index so downstream can see the gap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_index <= '0;
        end else if (w_push || w_drop) begin
            r_index <= r_index + {{(FIB_IDX_W-1){1'b0}}, 1'b1};
        end
    end
`else
    assign w_din    = in_term;
    assign out_term = w_head;
`endif

    fib_sync_fifo #(
        .DATA_WIDTH(FW),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (w_push),
        .pop  (w_pop),
        .din  (w_din),
        .full (w_full),
        .empty(w_empty),
        .head (w_head)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_overflow <= 1'b0;
            r_last     <= '0;
            r_dropped  <= '0;
        end else begin
            if (w_push) begin
                r_last <= in_term;
            end
            if (w_drop && (r_dropped != {DROP_WIDTH{1'b1}})) begin
                r_dropped <= r_dropped + {{(DROP_WIDTH-1){1'b0}}, 1'b1};
            end
            case (r_state)
                IDLE: begin
                    if (w_push) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_wrap) begin
                        r_state    <= OVF;
                        r_overflow <= 1'b1;
                    end
                end
                OVF: begin
                    r_state <= OVF;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_term_buffer.sv
// Directed bench for fib_term_buffer (8-bit terms, 4 entries, 4-bit drop counter).
// Expected terms are queued at issue time and checked by an independent output monitor.
module tb_fib_term_buffer;
    import fib_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int DRW   = 4;
    localparam int ACC   = 0;
    localparam int DROP  = 1;
    localparam int IGN   = 2;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           in_valid = 1'b0;
    logic [DW-1:0]  in_term = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [DW-1:0]  out_term;
    logic           overflow;
    logic [DRW-1:0] dropped;
    fib_buf_state_t dbg_state;
`ifdef FIB_BUF_INDEX_EN
    logic [31:0]    out_index;
`endif

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] exp_q[$];
    logic [31:0]   idx_q[$];
    logic [31:0]   tb_idx = 0;

    fib_term_buffer #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .DROP_WIDTH(DRW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_term  (in_term),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_term (out_term),
        .overflow (overflow),
        .dropped  (dropped),
`ifdef FIB_BUF_INDEX_EN
        .out_index(out_index),
`endif
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a transfer will happen at the next rising edge, so compare now.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'(out_term), 32'hFFFF_FFFF);
            end else begin
                check("out_term", 32'(out_term), 32'(exp_q.pop_front()));
`ifdef FIB_BUF_INDEX_EN
                check("out_index", out_index, idx_q.pop_front());
`else
                void'(idx_q.pop_front());
`endif
            end
        end
    end

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        idx_q.delete();
        tb_idx = 0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_dropped", 32'(dropped), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic push_term(input logic [DW-1:0] v, input int kind);
        in_valid = 1'b1;
        in_term  = v;
        if (kind == ACC) begin
            exp_q.push_back(v);
            idx_q.push_back(tb_idx);
        end
        if (kind != IGN) tb_idx++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] seq1 [5] = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd5};
        logic [DW-1:0] seq2 [8] = '{8'd8, 8'd13, 8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233};
        logic [DW-1:0] seq3 [6] = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8};

        @(posedge clk);
        #1;
        check("rst_out_term", 32'(out_term), 32'd0);
        do_reset();

        // 1: first terms flow through one cycle later
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_term(seq1[i], ACC);
            check("latency_valid", 32'(out_valid), 32'd1);
        end
        idle_cycles(2);
        check("t1_overflow", 32'(overflow), 32'd0);
        check("t1_dropped", 32'(dropped), 32'd0);
        check("t1_state", 32'(dbg_state), 32'(RUN));

        // 2: 377 mod 256 = 121 is a wrap
        for (int i = 0; i < 8; i++) push_term(seq2[i], ACC);
        push_term(8'd121, IGN);
        check("t2_overflow", 32'(overflow), 32'd1);
        check("t2_state", 32'(dbg_state), 32'(OVF));
        push_term(8'd250, IGN);
        idle_cycles(3);
        check("t2_overflow_sticky", 32'(overflow), 32'd1);
        check("t2_ignored_valid", 32'(out_valid), 32'd0);
        check("t2_ignored_drop", 32'(dropped), 32'd0);
        check("t2_drained", 32'(exp_q.size()), 32'd0);

        // 3: stalled consumer keeps the first four, drops two
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_term(seq3[i], (i < 4) ? ACC : DROP);
        check("t3_dropped", 32'(dropped), 32'd2);
        check("t3_out_valid", 32'(out_valid), 32'd1);
        check("t3_head", 32'(out_term), 32'd1);
        out_ready = 1'b1;
        idle_cycles(4);
        check("t3_empty", 32'(out_valid), 32'd0);
        check("t3_held_term", 32'(out_term), 32'd3);

        // 4: full FIFO with push and pop in the same cycle
        out_ready = 1'b0;
        push_term(8'd5, ACC);
        push_term(8'd8, ACC);
        push_term(8'd13, ACC);
        push_term(8'd21, ACC);
        out_ready = 1'b1;
        push_term(8'd34, ACC);
        out_ready = 1'b0;
        check("t4_dropped_same", 32'(dropped), 32'd2);
        push_term(8'd55, DROP);
        check("t4_still_full", 32'(dropped), 32'd3);
        out_ready = 1'b1;
        idle_cycles(4);
        check("t4_empty", 32'(out_valid), 32'd0);
        check("t4_drained", 32'(exp_q.size()), 32'd0);

        // 5: drop counter saturates
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_term(8'd55, ACC);
        for (int i = 0; i < 20; i++) push_term(8'd55, DROP);
        check("t5_saturate", 32'(dropped), 32'd15);

        // 6: reset with three entries held and overflow set
        out_ready = 1'b1;
        idle_cycles(1);
        out_ready = 1'b0;
        push_term(8'd1, IGN);
        check("t6_overflow", 32'(overflow), 32'd1);
        check("t6_held", 32'(out_valid), 32'd1);
        push_term(8'd200, IGN);
        check("t6_ovf_no_drop", 32'(dropped), 32'd15);
        do_reset();
        out_ready = 1'b1;
        push_term(8'd1, ACC);
        check("t6_first_valid", 32'(out_valid), 32'd1);
        check("t6_first_state", 32'(dbg_state), 32'(RUN));
        push_term(8'd1, ACC);
        idle_cycles(3);
        check("t6_overflow_clear", 32'(overflow), 32'd0);
        check("t6_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
